// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: IorD select, op and exception encodings, sequencer states and source-select helpers
package mem_ctrl_pkg;
  localparam logic [2:0] SEL_REGA   = 3'd0;
  localparam logic [2:0] SEL_PC     = 3'd1;
  localparam logic [2:0] SEL_ALUOUT = 3'd2;
  localparam logic [2:0] SEL_EXC0   = 3'd3;
  localparam logic [2:0] SEL_EXC1   = 3'd4;
  localparam logic [2:0] SEL_EXC2   = 3'd5;
  localparam logic [2:0] OP_FETCH   = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_STORE   = 3'd2;
  localparam logic [2:0] OP_SLOAD   = 3'd3;
  localparam logic [2:0] OP_SSTORE  = 3'd4;
  localparam logic [1:0] EXC_INVALID = 2'd0;
  localparam logic [1:0] EXC_OVF     = 2'd1;
  localparam logic [1:0] EXC_DIV0    = 2'd2;
  localparam logic [1:0] EXC_RSVD    = 2'd3;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, DONE} state_t;
  function automatic logic [2:0] op_sel(input logic [2:0] op);
    return op == OP_FETCH ? SEL_PC : (op == OP_LOAD || op == OP_STORE) ? SEL_ALUOUT : SEL_REGA;
  endfunction
  function automatic logic [2:0] exc_sel(input logic [1:0] code);
    return code == EXC_OVF ? SEL_EXC1 : code == EXC_DIV0 ? SEL_EXC2 : SEL_EXC0;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable 3-bit down-counter that saturates at zero; ports clk, reset, load, load_val in, zero out
module mem_wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       zero
);
  logic [2:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 3'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle memory-access and exception-entry sequencer; in clk, reset, start, op, exc_req, exc_code; out iord_sel, mem_wr, ir_wr, mdr_wr, epc_wr, pc_vec_wr, ready, done, illegal_op
module mem_access_seq
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] iord_sel,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       mdr_wr,
  output logic       epc_wr,
  output logic       pc_vec_wr,
  output logic       ready,
  output logic       done,
  output logic       illegal_op
);
  state_t state, state_nx;
  logic [2:0] sel_q, op_q;
  logic [1:0] code_q;
  logic exc_q, pend, ill_q, wzero, accept, go_acc, go_exc, is_store;
  assign accept = state == IDLE && !pend && start && !exc_req;
  assign go_acc = accept && op <= OP_SSTORE;
  assign go_exc = state == IDLE && pend;
  assign is_store = !exc_q && (op_q == OP_STORE || op_q == OP_SSTORE);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sel_q <= SEL_PC;
      op_q <= OP_FETCH;
      code_q <= EXC_INVALID;
      exc_q <= 1'b0;
      pend <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      ill_q <= accept && op > OP_SSTORE;
      // a new request on the launch edge re-arms the flag for a follow-up entry
      pend <= exc_req || (pend && !go_exc);
      if (exc_req) code_q <= exc_code;
      if (go_exc) begin
        sel_q <= exc_sel(code_q);
        exc_q <= 1'b1;
      end else if (go_acc) begin
        sel_q <= op_sel(op);
        op_q <= op;
        exc_q <= 1'b0;
      end
    end
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = (go_exc || go_acc) ? ADDR : IDLE;
      ADDR:    state_nx = WAIT;
      WAIT:    state_nx = wzero ? (is_store ? DONE : CAPTURE) : WAIT;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  mem_wait_timer u_timer (
    .clk(clk),
    .reset(reset),
    .load(state == ADDR),
    .load_val(3'(MEM_WAIT - 1)),
    .zero(wzero)
  );
  assign iord_sel = state == IDLE ? SEL_PC : sel_q;
  assign mem_wr = state == ADDR && is_store;
  assign epc_wr = state == ADDR && exc_q;
  assign ir_wr = state == CAPTURE && !exc_q && op_q == OP_FETCH;
  assign mdr_wr = state == CAPTURE && (exc_q || op_q != OP_FETCH);
  assign done = state == DONE;
  assign pc_vec_wr = state == DONE && exc_q;
  assign ready = state == IDLE && !pend;
  assign illegal_op = ill_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed and random stimulus checked cycle by cycle against a schedule-queue reference model
module tb_mem_access_seq;
  localparam int MW = 2;
  typedef struct packed {
    logic [2:0] sel;
    logic mw, ir, mdr, epc, pcv, dn;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, exc_req = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] exc_code = '0;
  logic [2:0] iord_sel;
  logic mem_wr, ir_wr, mdr_wr, epc_wr, pc_vec_wr, ready, done, illegal_op;
  int checks = 0, passed = 0, cyc = 0;
  ent_t q[$];
  logic pend = 1'b0, ill = 1'b0;
  logic [1:0] code = '0;
  mem_access_seq #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .exc_req(exc_req), .exc_code(exc_code),
    .iord_sel(iord_sel), .mem_wr(mem_wr), .ir_wr(ir_wr), .mdr_wr(mdr_wr), .epc_wr(epc_wr),
    .pc_vec_wr(pc_vec_wr), .ready(ready), .done(done), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  task automatic plan(input logic [2:0] sel, input logic store, input logic fetch, input logic exc);
    ent_t e;
    e = '0; e.sel = sel; e.mw = store; e.epc = exc;
    q.push_back(e);
    e = '0; e.sel = sel;
    for (int i = 0; i < MW; i++) q.push_back(e);
    if (!store) begin
      e = '0; e.sel = sel; e.ir = fetch; e.mdr = !fetch;
      q.push_back(e);
    end
    e = '0; e.sel = sel; e.dn = 1'b1; e.pcv = exc;
    q.push_back(e);
  endtask
  task automatic step(input logic r, input logic s, input logic [2:0] o, input logic e, input logic [1:0] c);
    ent_t f;
    logic [9:0] got, exp;
    logic idle;
    @(negedge clk);
    f = '0; f.sel = 3'b001;
    if (q.size() != 0) f = q[0];
    exp = {f.sel, f.mw, f.ir, f.mdr, f.epc, f.pcv, q.size() == 0 && !pend, f.dn, ill};
    got = {iord_sel, mem_wr, ir_wr, mdr_wr, epc_wr, pc_vec_wr, ready, done, illegal_op};
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL outs cyc%0d: got sel/mw/ir/mdr/epc/pcv/rdy/dn/ill=%b required %b", cyc, got, exp);
    cyc++;
    reset = r; start = s; op = o; exc_req = e; exc_code = c;
    idle = q.size() == 0;
    if (!idle) void'(q.pop_front());
    if (r) begin
      q.delete(); pend = 1'b0; ill = 1'b0;
    end else begin
      ill = 1'b0;
      if (idle && pend) begin
        plan(code == 2'd1 ? 3'd4 : code == 2'd2 ? 3'd5 : 3'd3, 1'b0, 1'b0, 1'b1);
        pend = 1'b0;
      end else if (idle && s && !e) begin
        if (o > 3'd4) ill = 1'b1;
        else plan(o == 3'd0 ? 3'd1 : (o == 3'd1 || o == 3'd2) ? 3'd2 : 3'd0,
                  o == 3'd2 || o == 3'd4, o == 3'd0, 1'b0);
      end
      if (e) begin pend = 1'b1; code = c; end
    end
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0);
    idle_n(2);
    step(0, 1, 3'd0, 0, 0); idle_n(7);
    step(0, 1, 3'd2, 0, 0); idle_n(6);
    step(0, 1, 3'd3, 0, 0); idle_n(7);
    step(0, 1, 3'd0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 1, 2'd1); idle_n(14);
    step(0, 1, 3'd1, 1, 2'd3); idle_n(9);
    step(0, 0, 0, 1, 2'd0); step(0, 0, 0, 1, 2'd2); idle_n(9);
    step(0, 1, 3'd2, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 1, 3'd6, 0, 0); idle_n(3);
    step(0, 1, 3'd4, 0, 0); idle_n(6);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 14) == 0, 2'($urandom_range(0, 3)));
    idle_n(12);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
